slot_dma_window: RTL and testbench



---
 rtl/slot_dma_window.sv | 167 ++++++++++++++++
 tb/tb_slot_dma_window.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_dma_window.sv
// slot_dma_window: Apple II slot register window with up to three
// auto-stepping SRAM pointers. Bus accesses are sequenced by a 3-bit
// state counter S that restarts at every PHI1 rising edge.
module slot_dma_window #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned CHANNELS = 2
) (
  input  logic              C7M,
  input  logic              nRES,
  input  logic              PHI1,
  input  logic [3:0]        A,
  input  logic              nWE,
  input  logic              nDEVSEL,
  input  logic              nIOSEL,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic [7:0]        RD_in,
  output logic [7:0]        RD_out,
  output logic              RD_oe,
  output logic [ADDR_W-1:0] RA,
  output logic              RAMCS
);

  localparam int unsigned MW = 2 * CHANNELS;

  typedef logic [ADDR_W-1:0] ptr_t;

  // Bus sequencing state (posedge C7M domain)
  logic [2:0]          s_q, s_d;
  logic                phi1_q;
  logic                phi0seen_q;
  logic                dben_q;
  logic                csen_q;
  logic                regen_q;

  // Register file (negedge C7M domain)
  ptr_t                ptr_q [CHANNELS];
  ptr_t                ptr_d [CHANNELS];
  logic [MW-1:0]       mode_q, mode_d;
  logic [CHANNELS-1:0] pend_q, pend_d;

  // Address decode
  logic [1:0]          ch;
  logic [1:0]          bsel;
  logic                ch_ok;
  logic                dp_sel;
  logic                bus_act;
  ptr_t                sel_ptr;
  logic [7:0]          reg_byte;

  assign ch      = A[3:2];
  assign bsel    = A[1:0];
  assign ch_ok   = {30'd0, ch} < CHANNELS;
  assign dp_sel  = ~nDEVSEL & ch_ok & (bsel == 2'd3);
  assign bus_act = ~nDEVSEL & regen_q;

  // Replace one byte lane of a pointer; lanes beyond ADDR_W fall off the shift.
  function automatic ptr_t put_byte(input ptr_t p, input logic [1:0] b,
                                    input logic [7:0] d);
    ptr_t m;
    m = ptr_t'(8'hFF) << {b, 3'b000};
    return (p & ~m) | ((ptr_t'(d) << {b, 3'b000}) & m);
  endfunction

  // Pointer addressed by A[3:2]; absent channels fall back to channel 0
  always_comb begin
    sel_ptr = ptr_q[0];
    for (int unsigned c = 1; c < CHANNELS; c++) begin
      if (ch == 2'(c)) sel_ptr = ptr_q[c];
    end
  end

  // Register readback mux (MODE, pointer bytes, zero elsewhere)
  always_comb begin
    reg_byte = '0;
    if (A == 4'hF) begin
      reg_byte = 8'(mode_q);
    end else if (ch_ok && bsel != 2'd3) begin
      reg_byte = 8'(sel_ptr >> {bsel, 3'b000});
    end
  end

  assign D_oe   = dben_q & nWE & ~nDEVSEL & regen_q;
  assign D_out  = D_oe ? (dp_sel ? RD_in : reg_byte) : 8'h00;
  assign RD_out = D_in;
  assign RD_oe  = dben_q & ~nWE & dp_sel & regen_q;
  assign RA     = sel_ptr;
  assign RAMCS  = csen_q & dp_sel & regen_q;

  // Next state counter: restart on qualified PHI1 rise, else count and saturate
  always_comb begin
    s_d = s_q;
    if (PHI1 && !phi1_q && phi0seen_q) begin
      s_d = 3'd1;
    end else if (s_q != 3'd0 && s_q != 3'd7) begin
      s_d = s_q + 3'd1;
    end
  end

  // Bus-phase sequencing and strobe enables
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      s_q        <= '0;
      phi1_q     <= 1'b0;
      phi0seen_q <= 1'b0;
      dben_q     <= 1'b0;
      csen_q     <= 1'b0;
      regen_q    <= 1'b0;
    end else begin
      s_q    <= s_d;
      phi1_q <= PHI1;
      if (!PHI1) phi0seen_q <= 1'b1;
      dben_q <= (s_q >= 3'd4);
      csen_q <= ((s_q == 3'd4) && nWE) || (s_q >= 3'd5);
      if (s_q == 3'd4 && !nIOSEL) regen_q <= 1'b1;
    end
  end

  // Register writes and access marking at S6; deferred pointer steps at S1.
  // Splitting write and step across two edges lets a step act on a value
  // written in the previous bus cycle and samples MODE at step time.
  always_comb begin
    ptr_d  = ptr_q;
    mode_d = mode_q;
    pend_d = pend_q;
    if (s_q == 3'd6 && bus_act) begin
      if (!nWE) begin
        if (A == 4'hF) begin
          mode_d = D_in[MW-1:0];
        end else begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch == 2'(c) && bsel != 2'd3) ptr_d[c] = put_byte(ptr_q[c], bsel, D_in);
          end
        end
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (ch == 2'(c) && bsel == 2'd3) pend_d[c] = 1'b1;
      end
    end else if (s_q == 3'd1) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (pend_q[c]) begin
          case (mode_q[2*c +: 2])
            2'b00:   ptr_d[c] = ptr_q[c] + ptr_t'(1);
            2'b01:   ptr_d[c] = ptr_q[c] - ptr_t'(1);
            default: ptr_d[c] = ptr_q[c];
          endcase
          pend_d[c] = 1'b0;
        end
      end
    end
  end

  // Register file update on the falling edge of C7M
  always_ff @(negedge C7M or negedge nRES) begin
    if (!nRES) begin
      for (int unsigned c = 0; c < CHANNELS; c++) ptr_q[c] <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_slot_dma_window.sv
// Scoreboard bench for slot_dma_window: each bus cycle pushes expected bus
// responses; a monitor pops and compares when the DUT asserts a drive/select.
module tb_slot_dma_window;

  localparam int unsigned AW   = 20;
  localparam int unsigned CH   = 2;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic          C7M = 1'b0;
  logic          nRES = 1'b0;
  logic          PHI1 = 1'b0;
  logic [3:0]    A = '0;
  logic          nWE = 1'b1;
  logic          nDEVSEL = 1'b1;
  logic          nIOSEL = 1'b1;
  logic [7:0]    D_in = '0;
  logic [7:0]    D_out;
  logic          D_oe;
  logic [7:0]    RD_in = '0;
  logic [7:0]    RD_out;
  logic          RD_oe;
  logic [AW-1:0] RA;
  logic          RAMCS;

  always #5 C7M = ~C7M;

  slot_dma_window #(.ADDR_W(AW), .CHANNELS(CH)) dut (
    .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .D_in(D_in), .D_out(D_out),
    .D_oe(D_oe), .RD_in(RD_in), .RD_out(RD_out), .RD_oe(RD_oe),
    .RA(RA), .RAMCS(RAMCS)
  );

  int checks = 0;
  int errors = 0;
  int n_doe  = 0;

  logic [7:0]    rd_q[$];
  logic [7:0]    wr_q[$];
  logic [AW-1:0] ra_q[$];

  // Reference model state
  int unsigned m_ptr[3];
  int unsigned m_mode;
  bit          m_regen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) m_ptr[i] = 0;
    m_mode  = 0;
    m_regen = 0;
  endfunction

  function automatic logic [7:0] m_read(input int unsigned off, input logic [7:0] rdin);
    int unsigned c = off / 4;
    int unsigned b = off % 4;
    if (off == 15) return 8'(m_mode);
    if (c < CH) begin
      if (b == 3) return rdin;
      return 8'((m_ptr[c] >> (8 * b)) & 255);
    end
    return 8'h00;
  endfunction

  function automatic void m_write(input int unsigned off, input int unsigned d);
    int unsigned c = off / 4;
    int unsigned b = off % 4;
    if (off == 15) m_mode = d & ((1 << (2 * CH)) - 1);
    else if (c < CH && b < 3)
      m_ptr[c] = ((m_ptr[c] & ~(32'd255 << (8 * b))) | (d << (8 * b))) & MASK;
  endfunction

  function automatic void m_step(input int unsigned c);
    case ((m_mode >> (2 * c)) & 3)
      0:       m_ptr[c] = (m_ptr[c] + 1) & MASK;
      1:       m_ptr[c] = (m_ptr[c] + MASK) & MASK;
      default: ;
    endcase
  endfunction

  function automatic logic [AW-1:0] m_ra(input int unsigned off);
    int unsigned c = off / 4;
    return AW'((c < CH) ? m_ptr[c] : m_ptr[0]);
  endfunction

  // One 6502 bus cycle: PHI1 high for 4 C7M periods, low for 4; bus signals
  // change in S2, after the previous cycle's strobes have dropped.
  task automatic bus_cycle(input bit io, input bit dev, input bit wr,
                           input logic [3:0] off, input logic [7:0] din, input bit rst_mid);
    logic [7:0] rdin;
    logic [5:0] prof;
    logic [5:0] prof_exp;
    bit en, dp;
    rdin = 8'($urandom);
    prof = '0;
    en = dev && m_regen;
    dp = en && (off[1:0] == 2'd3) && (int'(off[3:2]) < CH);
    if (en && !wr) rd_q.push_back(m_read(off, rdin));
    if (dp && wr)  wr_q.push_back(din);
    if (dp)        ra_q.push_back(m_ra(off));
    for (int s = 2; s <= 7; s++)
      prof_exp[s-2] = dp && (wr ? (s >= 6) : (s >= 5)) && !(rst_mid && s == 7);
    if (en && wr) m_write(off, din);
    if (io) m_regen = 1;
    if (dp) m_step(off / 4);
    if (rst_mid) m_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge C7M); #2;
      PHI1 = (i < 4);
      if (i == 2) begin
        A = off; nWE = ~wr; nDEVSEL = ~dev; nIOSEL = ~io; D_in = din; RD_in = rdin;
      end
      if (i == 7 && rst_mid) begin
        nRES = 1'b0;
        #1;
        check("reset_mid_D_oe", D_oe, 0);
        check("reset_mid_RAMCS", RAMCS, 0);
        nRES = 1'b1;
      end
      if (i >= 2) begin
        @(negedge C7M);
        prof[i-2] = RAMCS;
      end
    end
    check("ramcs_profile", prof, prof_exp);
  endtask

  task automatic rd(input logic [3:0] off);
    bus_cycle(0, 1, 0, off, 8'h00, 0);
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    bus_cycle(0, 1, 1, off, d, 0);
  endtask

  // Monitor: compare on each rising edge of the DUT's drive and select outputs
  initial begin
    logic doe_p, rdoe_p, cs_p;
    logic [7:0] e8;
    logic [AW-1:0] ea;
    doe_p = 0; rdoe_p = 0; cs_p = 0;
    forever begin
      @(negedge C7M);
      if (D_oe && !doe_p) begin
        n_doe++;
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_D_oe: got D_out 0x%0h expected no drive at %0t", D_out, $time);
        end else begin
          e8 = rd_q.pop_front();
          check("read_data", D_out, e8);
        end
      end
      if (RD_oe && !rdoe_p) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_RD_oe: got RD_out 0x%0h expected no drive at %0t", RD_out, $time);
        end else begin
          e8 = wr_q.pop_front();
          check("sram_write_data", RD_out, e8);
        end
      end
      if (RAMCS && !cs_p) begin
        if (ra_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_RAMCS: got RA 0x%0h expected no select at %0t", RA, $time);
        end else begin
          ea = ra_q.pop_front();
          check("sram_address", RA, ea);
        end
      end
      doe_p = D_oe; rdoe_p = RD_oe; cs_p = RAMCS;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int unsigned off;
    m_reset();
    repeat (3) @(posedge C7M);
    #2;
    check("reset_D_oe", D_oe, 0);
    check("reset_RD_oe", RD_oe, 0);
    check("reset_RAMCS", RAMCS, 0);
    check("reset_RA", RA, 0);
    check("reset_D_out", D_out, 0);
    nRES = 1'b1;

    // Accesses before any IOSEL must be ignored
    n0 = n_doe;
    rd(4'h0);
    wr(4'h0, 8'hFF);
    bus_cycle(0, 0, 0, 4'h0, 8'h00, 0);
    check("no_drive_before_iosel", n_doe - n0, 0);
    bus_cycle(1, 0, 0, 4'h0, 8'h00, 0);
    rd(4'h0);

    // Byte writes and readback
    wr(4'h0, 8'h56); wr(4'h1, 8'h34); wr(4'h2, 8'h12);
    check("ra_after_byte_writes", RA, 32'h23456);
    rd(4'h0); rd(4'h1); rd(4'h2);

    // Carry across byte boundary on +1
    wr(4'h0, 8'hFF); wr(4'h1, 8'hFF); wr(4'h2, 8'h00); wr(4'hF, 8'h00);
    rd(4'h3);
    rd(4'h0); rd(4'h1); rd(4'h2);

    // Borrow wrap on channel 1, channel 0 untouched
    wr(4'h4, 8'h00); wr(4'h5, 8'h00); wr(4'h6, 8'h00); wr(4'hF, 8'h04);
    wr(4'h7, 8'hA5);
    rd(4'h4); rd(4'h5); rd(4'h6); rd(4'h0); rd(4'h1); rd(4'h2);

    // Hold mode
    wr(4'hF, 8'h02);
    rd(4'h3); rd(4'h3); rd(4'h3);
    rd(4'h0); rd(4'h1); rd(4'h2); rd(4'hF);

    // Unused MODE bits and unused offsets
    wr(4'hF, 8'hFF); rd(4'hF);
    wr(4'h9, 8'h77); rd(4'h9); rd(4'hB); rd(4'hD);

    // Reset between S6 and S1 after a data-port access
    wr(4'hF, 8'h00);
    bus_cycle(0, 1, 0, 4'h3, 8'h00, 1);
    bus_cycle(1, 0, 0, 4'h0, 8'h00, 0);
    rd(4'h0); rd(4'h1); rd(4'h2); rd(4'h4); rd(4'h5); rd(4'h6);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int unsigned k = $urandom_range(0, 99);
      if (k < 8) begin
        bus_cycle(0, 0, 0, 4'($urandom), 8'($urandom), 0);
      end else if (k < 13) begin
        bus_cycle(1, 0, 0, 4'($urandom), 8'h00, 0);
      end else begin
        off = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) off = 4 * $urandom_range(0, CH - 1) + 3;
        if ($urandom_range(0, 2) == 0)
          bus_cycle(0, 1, 1, 4'(off), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 0);
        else
          bus_cycle(0, 1, $urandom_range(0, 1) == 1, 4'(off), 8'($urandom),
                    (off % 4 == 3) && ($urandom_range(0, 49) == 0));
      end
    end

    bus_cycle(0, 0, 0, 4'h0, 8'h00, 0);
    check("read_queue_drained", rd_q.size(), 0);
    check("write_queue_drained", wr_q.size(), 0);
    check("addr_queue_drained", ra_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
